ad7383_sample_framer: RTL and testbench
=======================================

Name: ad7383_sample_framer

Overview:
Downstream stage of the AD7383 AXI-Stream source. Consumes packed two-channel samples {chB[15:0], chA[15:0]} one word per conversion, buffers them in a FIFO, and re-emits them as fixed-length AXI-Stream frames with generated TLAST for the DMA.
- The ADC cannot be stalled, so input is never back-pressured in normal operation.
- Samples arriving with the FIFO full are dropped and counted.

Parameters:
FRAME_LEN, 256, data words per frame (2..65535); TLAST on the last word.
FIFO_DEPTH, 512, buffer depth in words; power of two, at least 2.
CNT_W, 16, width of the drop counter.

Ports:
clk_i  in  1  single clock for all logic.
rst_i  in  1  synchronous, active-high reset.
enable_i  in  1  framing enable; a frame in progress always completes.
s_axis_tdata  in  32  packed sample {chB, chA}.
s_axis_tvalid  in  1  sample valid.
s_axis_tlast  in  1  ignored.
s_axis_tready  out  1  0 during reset, 1 otherwise.
m_axis_tdata  out  32  output word.
m_axis_tvalid  out  1  output valid.
m_axis_tlast  out  1  last word of a frame.
m_axis_tready  in  1  downstream ready.
overflow_o  out  1  sticky flag: a sample was dropped since reset.
drop_cnt_o  out  CNT_W  dropped-sample count, saturating.
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_i high at a clock edge):
  - All outputs go to 0, including s_axis_tready.
  - FIFO empties; word counters, frame sequence and drop count clear.
  - Reset asserted mid-frame discards the partial frame. After release, the first accepted sample is word 0.
- Input accept: a handshake is s_axis_tvalid & s_axis_tready.
- Write qualifier: a handshake writes when framing is active, where active = enable_i | (in_idx != 0).
  - enable_i low at in_idx==0 discards samples. These discards are not counted as drops.
  - enable_i falling mid-frame does not truncate the frame; writing continues until the frame completes.
- FIFO entry = {last, data}, last = (in_idx == FRAME_LEN-1).
  - in_idx increments on each write and wraps to 0 after FRAME_LEN-1.
- Drop: a qualified write with the FIFO full that is not matched by a same-cycle read is dropped.
  - in_idx does not advance, so every emitted frame is exactly FRAME_LEN words. Drops create gaps in time, not short frames.
  - drop_cnt_o increments, saturating at all-ones. overflow_o sets and stays set until reset.
- Simultaneous read and write with the FIFO full: the write succeeds and no drop occurs.
- Simultaneous read and write with the FIFO empty: the word is written and becomes visible the next cycle.
- Output is first-word-fall-through:
  - A sample written in cycle N is presented with m_axis_tvalid=1 in cycle N+1.
  - m_axis_tdata, m_axis_tlast and m_axis_tvalid are stable while m_axis_tvalid=1 and m_axis_tready=0.
  - The FIFO pops on m_axis_tvalid & m_axis_tready.
- fifo_level_o reflects writes and reads of the previous edge. It ranges 0..FIFO_DEPTH, with FIFO_DEPTH meaning full.
- Output state machine, states DATA and HDR (HDR exists only with the optional feature):
  - Without the feature: always DATA.
  - DATA presents the FIFO head.
  - On the tlast handshake, frame_seq increments (16-bit, wraps 0xFFFF->0x0000).

Optional Feature:
Macro AD7383_FRAME_HEADER_EN.
- Defined:
  - The output FSM resets to HDR.
  - In HDR, m_axis_tvalid = !empty and m_axis_tdata = {16'hA5A5, frame_seq}, m_axis_tlast=0. The FIFO is not popped.
  - On the HDR handshake, go to DATA.
  - On the DATA tlast handshake, return to HDR.
  - Each frame is therefore FRAME_LEN+1 beats. The header is emitted only once the frame's first sample is present.
- Not defined: no header; frames are FRAME_LEN beats and frame_seq is internal only.

Test Plan:
1. Reset: rst_i=1 for 3 cycles -> all outputs 0, s_axis_tready=0. After release, s_axis_tready=1 and fifo_level_o=0.
2. Basic framing, FRAME_LEN=4, m_axis_tready=1, enable_i=1, 8 samples 0x00010000..0x00080007 -> each appears one cycle after input; tlast on the 4th and 8th words; drop_cnt_o=0.
3. Back-pressure and overflow, FIFO_DEPTH=8, FRAME_LEN=4, m_axis_tready=0, 12 samples -> fifo_level_o=8, drop_cnt_o=4, overflow_o=1. Then m_axis_tready=1 drains 8 words, with tlast on words 4 and 8 and no data reordering.
4. Full with same-cycle read: FIFO full, m_axis_tready=1 with a continuous input stream -> no drops, level stays 8.
5. Enable gating: deassert enable_i after word 2 of a 4-word frame -> words 3 and 4 are still written with tlast on word 4. Subsequent samples are discarded with drop_cnt_o unchanged. Re-asserting enable_i starts at word 0.
6. With AD7383_FRAME_HEADER_EN defined, FRAME_LEN=2, 4 samples -> beat sequence 0xA5A50000, d0, d1(tlast), 0xA5A50001, d2, d3(tlast). Random m_axis_tready holds data stable while stalled.

Source files
------------

// File: rtl/ad7383_sample_framer.sv
// AD7383 sample framer: FIFO-buffered {chB,chA} words re-emitted as fixed-length AXI-Stream frames.
// Optional per-frame header word enabled by defining AD7383_FRAME_HEADER_EN.
module ad7383_sample_framer #(
    parameter int FRAME_LEN  = 256,
    parameter int FIFO_DEPTH = 512,
    parameter int CNT_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic [31:0]                   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [31:0]                   m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic                          overflow_o,
    output logic [CNT_W-1:0]              drop_cnt_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [15:0]   LAST_IDX = 16'(FRAME_LEN - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    logic [32:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [15:0]      in_idx;
    logic             ready_q;
    logic [CNT_W-1:0] drop_cnt;
    logic             ovf_q;

    logic        empty;
    logic        full;
    logic        hs;
    logic        wr_req;
    logic        wr_en;
    logic        drop;
    logic        pop;
    logic        hdr_sel;
    logic [31:0] hdr_word;
    logic [32:0] head;
    logic        unused_tlast;

    assign unused_tlast = s_axis_tlast;

    assign empty  = (level == '0);
    assign full   = (level == FULL_LVL);
    assign head   = mem[rd_ptr];

    assign hs     = s_axis_tvalid & ready_q;
    assign wr_req = hs & (enable_i | (in_idx != 16'd0));
    assign pop    = m_axis_tvalid & m_axis_tready & ~hdr_sel;
    // A full FIFO still accepts when the head leaves in the same cycle
    assign wr_en  = wr_req & (~full | pop);
    assign drop   = wr_req & full & ~pop;

    assign s_axis_tready = ready_q;
    assign m_axis_tvalid = ~empty;
    assign m_axis_tdata  = empty ? 32'd0 : (hdr_sel ? hdr_word : head[31:0]);
    assign m_axis_tlast  = ~empty & ~hdr_sel & head[32];
    assign overflow_o    = ovf_q;
    assign drop_cnt_o    = drop_cnt;
    assign fifo_level_o  = level;

    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem[wr_ptr] <= {(in_idx == LAST_IDX), s_axis_tdata};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            in_idx   <= '0;
            drop_cnt <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                in_idx <= (in_idx == LAST_IDX) ? 16'd0 : in_idx + 16'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (wr_en & ~pop)
                level <= level + LW'(1);
            else if (pop & ~wr_en)
                level <= level - LW'(1);
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_cnt != '1)
                    drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

`ifdef AD7383_FRAME_HEADER_EN
    typedef enum logic {ST_DATA, ST_HDR} state_t;

    state_t      state;
    logic [15:0] frame_seq;

    // Header waits for the frame's first sample so it never precedes an empty frame
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_HDR;
            frame_seq <= '0;
        end else if (m_axis_tvalid & m_axis_tready) begin
            unique case (state)
                ST_HDR: state <= ST_DATA;
                ST_DATA: begin
                    if (head[32]) begin
                        state     <= ST_HDR;
                        frame_seq <= frame_seq + 16'd1;
                    end
                end
                default: state <= ST_HDR;
            endcase
        end
    end

    assign hdr_sel  = (state == ST_HDR);
    assign hdr_word = {16'hA5A5, frame_seq};
`else
    assign hdr_sel  = 1'b0;
    assign hdr_word = 32'd0;
`endif

endmodule

// File: tb/tb_ad7383_sample_framer.sv
// Directed bench for ad7383_sample_framer (FIFO_DEPTH=8; FRAME_LEN=4, or 2 with header build).
module tb_ad7383_sample_framer;
`ifdef AD7383_FRAME_HEADER_EN
    localparam int FL = 2;
`else
    localparam int FL = 4;
`endif
    localparam int FD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic        ovf;
    logic [15:0] drop;
    logic [3:0]  level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ad7383_sample_framer #(
        .FRAME_LEN (FL),
        .FIFO_DEPTH(FD),
        .CNT_W     (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (en),
        .s_axis_tdata (s_data),
        .s_axis_tvalid(s_valid),
        .s_axis_tlast (s_last),
        .s_axis_tready(s_ready),
        .m_axis_tdata (m_data),
        .m_axis_tvalid(m_valid),
        .m_axis_tlast (m_last),
        .m_axis_tready(m_ready),
        .overflow_o   (ovf),
        .drop_cnt_o   (drop),
        .fifo_level_o (level)
    );

    typedef struct {
        logic        en;
        logic        vld;
        logic [31:0] d;
        logic        ev;
        logic [31:0] ed;
        logic        el;
        int          elvl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic e, logic v, logic [31:0] d,
                                logic ev, logic [31:0] ed, logic el, int lv);
        vec_t r;
        r.en = e; r.vld = v; r.d = d;
        r.ev = ev; r.ed = ed; r.el = el; r.elvl = lv;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic v,
                         input logic [31:0] d, input logic rdy);
        rst = r; en = e; s_valid = v; s_data = d; m_ready = rdy;
    endtask

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(1'b0, tbl[i].en, tbl[i].vld, tbl[i].d, 1'b1);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_data", i), m_data, tbl[i].ed);
                chk($sformatf("vec%0d_last", i), 32'(m_last), 32'(tbl[i].el));
            end
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].elvl));
            chk($sformatf("vec%0d_drop", i), 32'(drop), 32'd0);
        end
    endtask

    task automatic do_reset(input int n);
        drive(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
        for (int i = 0; i < n; i++) tick();
        chk("rst_tready", 32'(s_ready), 32'd0);
        chk("rst_tvalid", 32'(m_valid), 32'd0);
        chk("rst_tdata", m_data, 32'd0);
        chk("rst_tlast", 32'(m_last), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        tick();
        chk("rel_tready", 32'(s_ready), 32'd1);
        chk("rel_level", 32'(level), 32'd0);
    endtask

`ifdef AD7383_FRAME_HEADER_EN
    logic [31:0] hexp [6];
    logic        hlst [6];
`else
    logic [31:0] dexp [8];
    logic        dlst [8];
`endif

    initial begin
        s_last = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);

`ifdef AD7383_FRAME_HEADER_EN
        hexp = '{32'hA5A50000, 32'h00010000, 32'h00020001,
                 32'hA5A50001, 32'h00030002, 32'h00040003};
        hlst = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset(3);
        chk("hdr_idle_valid", 32'(m_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, {16'(i + 1), 16'(i)}, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        begin
            int k = 0;
            int cyc = 0;
            while (k < 6 && cyc < 200) begin
                m_ready = 1'($urandom_range(0, 1));
                chk($sformatf("hdr_beat%0d_valid", k), 32'(m_valid), 32'd1);
                chk($sformatf("hdr_beat%0d_data", k), m_data, hexp[k]);
                chk($sformatf("hdr_beat%0d_last", k), 32'(m_last), 32'(hlst[k]));
                if (m_ready) k++;
                tick();
                cyc++;
            end
            chk("hdr_all_beats", 32'(k), 32'd6);
        end
        chk("hdr_end_valid", 32'(m_valid), 32'd0);
`else
        // basic framing: vectors 0..8
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1'b1, 1'b1, {16'(i + 1), 16'(i)},
                             1'b1, {16'(i + 1), 16'(i)}, (i % 4) == 3, 1));
        tbl.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 0));
        // enable gating: vectors 9..19
        tbl.push_back(mk(1'b1, 1'b1, 32'h400, 1'b1, 32'h400, 1'b0, 1));
        tbl.push_back(mk(1'b1, 1'b1, 32'h401, 1'b1, 32'h401, 1'b0, 1));
        tbl.push_back(mk(1'b0, 1'b1, 32'h402, 1'b1, 32'h402, 1'b0, 1));
        tbl.push_back(mk(1'b0, 1'b1, 32'h403, 1'b1, 32'h403, 1'b1, 1));
        tbl.push_back(mk(1'b0, 1'b1, 32'h404, 1'b0, 32'd0, 1'b0, 0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h405, 1'b0, 32'd0, 1'b0, 0));
        tbl.push_back(mk(1'b1, 1'b1, 32'h406, 1'b1, 32'h406, 1'b0, 1));
        tbl.push_back(mk(1'b1, 1'b1, 32'h407, 1'b1, 32'h407, 1'b0, 1));
        tbl.push_back(mk(1'b1, 1'b1, 32'h408, 1'b1, 32'h408, 1'b0, 1));
        tbl.push_back(mk(1'b1, 1'b1, 32'h409, 1'b1, 32'h409, 1'b1, 1));
        tbl.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 0));

        do_reset(3);
        run_vec(0, 8);

        // overflow under back-pressure
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, 1'b1, 32'h100 + 32'(i), 1'b0);
            tick();
            chk($sformatf("ovf_w%0d_level", i), 32'(level), (i < 8) ? 32'(i + 1) : 32'd8);
            chk($sformatf("ovf_w%0d_drop", i), 32'(drop), (i < 8) ? 32'd0 : 32'(i - 7));
            chk($sformatf("ovf_w%0d_flag", i), 32'(ovf), 32'(i >= 8));
            chk($sformatf("ovf_w%0d_head", i), m_data, 32'h100);
            chk($sformatf("ovf_w%0d_last", i), 32'(m_last), 32'd0);
        end
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("drain%0d_valid", j), 32'(m_valid), 32'd1);
            chk($sformatf("drain%0d_data", j), m_data, 32'h100 + 32'(j));
            chk($sformatf("drain%0d_last", j), 32'(m_last), 32'((j % 4) == 3));
            tick();
        end
        chk("drain_end_valid", 32'(m_valid), 32'd0);
        chk("drain_end_level", 32'(level), 32'd0);
        chk("drain_end_drop", 32'(drop), 32'd4);

        // full FIFO with concurrent read
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b1, 32'h200 + 32'(i), 1'b0);
            tick();
        end
        chk("full_level", 32'(level), 32'd8);
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b1, 1'b1, 32'h300 + 32'(c), 1'b1);
            tick();
            chk($sformatf("fullrw%0d_level", c), 32'(level), 32'd8);
            chk($sformatf("fullrw%0d_drop", c), 32'(drop), 32'd4);
            chk($sformatf("fullrw%0d_head", c), m_data, 32'h201 + 32'(c));
        end
        dexp = '{32'h206, 32'h207, 32'h300, 32'h301, 32'h302, 32'h303, 32'h304, 32'h305};
        dlst = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("fdrain%0d_data", j), m_data, dexp[j]);
            chk($sformatf("fdrain%0d_last", j), 32'(m_last), 32'(dlst[j]));
            tick();
        end
        chk("fdrain_end_level", 32'(level), 32'd0);

        // mid-frame reset with data queued
        drive(1'b0, 1'b1, 1'b1, 32'h306, 1'b0);
        tick();
        chk("pre_rst_level", 32'(level), 32'd1);
        do_reset(1);
        chk("post_rst_valid", 32'(m_valid), 32'd0);

        run_vec(9, 19);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1);
    end
endmodule
